// File: rtl/fir_pkg.sv
// fir_pkg: shared types and helpers for the time-multiplexed FIR filter.
// Holds the FSM state enum, accumulator sizing and result narrowing.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    // Accumulator width that cannot overflow over t full-precision products.
    function automatic int acc_width(
        input int d,
        input int c,
        input int t
    );
        return d + c + $clog2(t);
    endfunction

    // Clamp v to the signed w-bit range when sat is set; otherwise pass it
    // through so the caller's truncation to w bits wraps.
    function automatic logic signed [63:0] narrow(
        input logic signed [63:0] v,
        input int                 w,
        input bit                 sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: signed multiply-accumulate with registered accumulator.
// Ports: clk, rst_n, i_clr (zero acc), i_en (acc += a*b), i_a, i_b, o_acc.
module fir_mac_unit #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 37
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [A_W+B_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   r_acc;

    assign w_prod = i_a * i_b;
    assign o_acc  = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

endmodule

// File: rtl/fir_seq_filter.sv
// fir_seq_filter: TAPS-deep FIR, one shared MAC, one sample per TAPS+2 clocks.
// Ports: clk, rst_n (async, active low); run/sample_in request a new output;
// busy, out_valid, filter_data report it; coeff_we/addr/wdata load the
// coefficient bank in IDLE; clear zeroes the delay line in IDLE.
// Build option: define FIR_SATURATE_EN to clamp instead of wrap the output.
module fir_seq_filter
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEFF_W   = 16,
    parameter int TAPS      = 32,
    parameter int OUT_SHIFT = 15,
    localparam int ADDR_W   = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [DATA_W-1:0]  sample_in,
    output logic               busy,
    output logic               out_valid,
    output logic [DATA_W-1:0]  filter_data,
    input  logic               coeff_we,
    input  logic [ADDR_W-1:0]  coeff_addr,
    input  logic [COEFF_W-1:0] coeff_wdata,
    input  logic               clear
);

    localparam int ACC_W = acc_width(DATA_W, COEFF_W, TAPS);
    localparam logic [ADDR_W:0] ADDR_LIM = TAPS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(TAPS - 1);
`ifdef FIR_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    fir_state_t r_state;
    fir_state_t w_next;

    logic [ADDR_W-1:0]         r_idx;
    logic signed [DATA_W-1:0]  r_x [TAPS];
    logic signed [COEFF_W-1:0] r_c [TAPS];
    logic [DATA_W-1:0]         r_data;
    logic                      r_valid;

    logic w_accept;
    logic w_mac_en;
    logic w_load_out;
    logic w_clear_dl;
    logic w_coeff_wr;

    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [63:0]      w_narrow;
    logic                    w_unused_hi;

    assign busy        = run | (r_state != IDLE);
    assign out_valid   = r_valid;
    assign filter_data = r_data;

    // Out-of-range addresses only exist when TAPS is not a power of two.
    assign w_coeff_wr = (r_state == IDLE) && coeff_we
                        && ({1'b0, coeff_addr} < ADDR_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_mac_en   = 1'b0;
        w_load_out = 1'b0;
        w_clear_dl = 1'b0;
        unique case (r_state)
            IDLE: begin
                // clear has priority: a simultaneous run is dropped.
                if (clear) begin
                    w_clear_dl = 1'b1;
                end else if (run) begin
                    w_accept = 1'b1;
                    w_next   = MAC;
                end
            end
            MAC: begin
                w_mac_en = 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                w_load_out = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_mac_en) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_clear_dl) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                r_x[k] <= r_x[k-1];
            end
            r_x[0] <= $signed(sample_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                r_c[k] <= '0;
            end
        end else if (w_coeff_wr) begin
            r_c[coeff_addr] <= $signed(coeff_wdata);
        end
    end

    fir_mac_unit #(
        .A_W   (DATA_W),
        .B_W   (COEFF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_mac_en),
        .i_a   (r_x[r_idx]),
        .i_b   (r_c[r_idx]),
        .o_acc (w_acc)
    );

    assign w_shifted   = w_acc >>> OUT_SHIFT;
    assign w_narrow    = narrow(64'(w_shifted), DATA_W, SAT_EN);
    assign w_unused_hi = ^w_narrow[63:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_load_out;
            if (w_load_out) begin
                r_data <= w_narrow[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_filter.sv
// tb_fir_seq_filter: scoreboard bench for fir_seq_filter (TAPS=32).
// Expected outputs come from a behavioural FIR model kept in the bench.
module tb_fir_seq_filter;

    localparam int TAPS = 32;
    localparam int LAT  = TAPS + 1;
    localparam int PER  = TAPS + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] sample_in;
    logic        busy;
    logic        out_valid;
    logic [15:0] filter_data;
    logic        coeff_we;
    logic [4:0]  coeff_addr;
    logic [15:0] coeff_wdata;
    logic        clear;

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] m_x [TAPS];
    logic signed [15:0] m_c [TAPS];
    logic [15:0]        exp_q [$];

    fir_seq_filter #(
        .DATA_W    (16),
        .COEFF_W   (16),
        .TAPS      (TAPS),
        .OUT_SHIFT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .sample_in   (sample_in),
        .busy        (busy),
        .out_valid   (out_valid),
        .filter_data (filter_data),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .clear       (clear)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] calc_expected();
        logic signed [63:0] acc;
        logic signed [63:0] sh;
        acc = 64'sd0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + 64'(m_x[k]) * 64'(m_c[k]);
        end
        sh = acc >>> 15;
`ifdef FIR_SATURATE_EN
        if (sh > 64'sd32767)  sh = 64'sd32767;
        if (sh < -64'sd32768) sh = -64'sd32768;
`endif
        return sh[15:0];
    endfunction

    task automatic model_shift(input logic [15:0] s);
        for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = $signed(s);
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_x[k] = '0;
            m_c[k] = '0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        sample_in = '0;
        coeff_we = 1'b0;
        coeff_addr = '0;
        coeff_wdata = '0;
        clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_coeff(input int k, input logic [15:0] v);
        @(negedge clk);
        coeff_we = 1'b1;
        coeff_addr = 5'(k);
        coeff_wdata = v;
        @(posedge clk);
        m_c[k] = $signed(v);
        #1 coeff_we = 1'b0;
    endtask

    task automatic accept(input logic [15:0] s);
        @(negedge clk);
        run = 1'b1;
        sample_in = s;
        @(posedge clk);
        model_shift(s);
        exp_q.push_back(calc_expected());
        #1 run = 1'b0;
    endtask

    // Waits for out_valid; 'already' edges have passed since acceptance.
    task automatic collect(input string tag, input int already);
        int n;
        bit got;
        logic [15:0] e;
        n = already;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) got = 1'b1;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (!got) begin
            $display("FAIL %s timeout: no out_valid in %0d edges", tag, n);
            failures++;
            return;
        end
        if (n != LAT) begin
            $display("FAIL %s latency: got %0d edges, want %0d",
                     tag, n, LAT);
            failures++;
        end
        checks++;
        if (filter_data !== e) begin
            $display("FAIL %s data: got %h, want %h",
                     tag, filter_data, e);
            failures++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s busy: got %b, want 0", tag, busy);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || filter_data !== e) begin
            $display("FAIL %s pulse/hold: valid=%b data=%h, want 0/%h",
                     tag, out_valid, filter_data, e);
            failures++;
        end
    endtask

    task automatic filter_one(input logic [15:0] s, input string tag);
        accept(s);
        collect(tag, 0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || filter_data !== 16'h0)
        begin
            $display("FAIL reset: busy=%b valid=%b data=%h, want 0/0/0000",
                     busy, out_valid, filter_data);
            failures++;
        end
    endtask

    task automatic test_single_tap();
        write_coeff(0, 16'h7FFF);
        @(negedge clk);
        run = 1'b1;
        sample_in = 16'h1234;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_comb: got %b, want 1", busy);
            failures++;
        end
        @(posedge clk);
        model_shift(16'h1234);
        exp_q.push_back(calc_expected());
        #1 run = 1'b0;
        collect("single_tap", 0);
        checks++;
        if (filter_data !== 16'h1233) begin
            $display("FAIL single_tap_const: got %h, want 1233",
                     filter_data);
            failures++;
        end
    endtask

    task automatic test_impulse();
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coeff(k, 16'(k * 256));
        for (int n = 0; n < TAPS; n++) begin
            filter_one((n == 0) ? 16'h4000 : 16'h0000, "impulse");
            checks++;
            if (filter_data !== 16'(n * 128)) begin
                $display("FAIL impulse_%0d: got %h, want %h",
                         n, filter_data, 16'(n * 128));
                failures++;
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < TAPS; k++) write_coeff(k, 16'h7FFF);
        for (int n = 0; n < TAPS; n++) filter_one(16'h7FFF, "sat_pos");
        checks++;
`ifdef FIR_SATURATE_EN
        if (filter_data !== 16'h7FFF) begin
            $display("FAIL sat_pos_last: got %h, want 7fff", filter_data);
            failures++;
        end
`else
        if (filter_data !== 16'hFFC0) begin
            $display("FAIL wrap_pos_last: got %h, want ffc0", filter_data);
            failures++;
        end
`endif
        for (int n = 0; n < TAPS; n++) filter_one(16'h8000, "sat_neg");
        checks++;
`ifdef FIR_SATURATE_EN
        if (filter_data !== 16'h8000) begin
            $display("FAIL sat_neg_last: got %h, want 8000", filter_data);
            failures++;
        end
`else
        if (filter_data !== 16'h0020) begin
            $display("FAIL wrap_neg_last: got %h, want 0020", filter_data);
            failures++;
        end
`endif
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [15:0] e;
        pulses = 0;
        for (int k = 0; k < TAPS; k++) write_coeff(k, 16'(k * 64 - 900));
        for (int c = 0; c < 3 * PER; c++) begin
            @(negedge clk);
            run = 1'b1;
            sample_in = 16'(c * 97 + 5);
            @(posedge clk);
            if (c % PER == 0) begin
                model_shift(sample_in);
                exp_q.push_back(calc_expected());
            end
            #1;
            if (out_valid) begin
                pulses++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (c % PER != LAT) begin
                    $display("FAIL b2b_phase: pulse at %0d, want phase %0d",
                             c, LAT);
                    failures++;
                end
                checks++;
                if (filter_data !== e) begin
                    $display("FAIL b2b_data: got %h, want %h",
                             filter_data, e);
                    failures++;
                end
            end
        end
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (pulses != 3) begin
            $display("FAIL b2b_count: got %0d pulses, want 3", pulses);
            failures++;
        end
        @(posedge clk);
    endtask

    task automatic test_ignore_in_mac();
        bool_check: begin end
        accept(16'h0100);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL mac_busy: got %b, want 1", busy);
            failures++;
        end
        @(negedge clk);
        run = 1'b1;
        sample_in = 16'h7777;
        coeff_we = 1'b1;
        coeff_addr = 5'd0;
        coeff_wdata = 16'h1111;
        @(posedge clk);
        #1;
        run = 1'b0;
        coeff_we = 1'b0;
        collect("ignore_mac", 4);
        checks++;
        for (int i = 0; i < PER; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                $display("FAIL ignore_queue: extra out_valid at %0d, want none",
                         i);
                failures++;
                break;
            end
        end
        filter_one(16'h0200, "ignore_coeff");
    endtask

    task automatic test_clear();
        write_coeff(1, 16'h2000);
        filter_one(16'h0400, "clear_load0");
        filter_one(16'h0300, "clear_load1");
        @(negedge clk);
        clear = 1'b1;
        run = 1'b1;
        sample_in = 16'h5555;
        @(posedge clk);
        for (int k = 0; k < TAPS; k++) m_x[k] = '0;
        #1;
        clear = 1'b0;
        run = 1'b0;
        checks++;
        for (int i = 0; i < PER + 1; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                $display("FAIL clear_run: out_valid at %0d, want none", i);
                failures++;
                break;
            end
        end
        filter_one(16'h0000, "clear_zero");
        checks++;
        if (filter_data !== 16'h0000) begin
            $display("FAIL clear_zero_const: got %h, want 0000",
                     filter_data);
            failures++;
        end
        filter_one(16'h0100, "clear_coeff_kept");
    endtask

    task automatic test_reset_mid_mac();
        accept(16'h1234);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || filter_data !== 16'h0)
        begin
            $display("FAIL rst_mid: busy=%b valid=%b data=%h, want 0/0/0000",
                     busy, out_valid, filter_data);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        for (int i = 0; i < 2 * PER; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                $display("FAIL rst_mid_pulse: out_valid at %0d, want none", i);
                failures++;
                break;
            end
        end
        filter_one(16'h1234, "rst_mid_next");
        checks++;
        if (filter_data !== 16'h0000) begin
            $display("FAIL rst_mid_next_const: got %h, want 0000",
                     filter_data);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_ignore_in_mac();
        test_clear();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_seq_filter.md
# fir_seq_filter

Parametrised, time-multiplexed FIR filter for the audio/sensor sample path. It keeps a TAPS-deep sample delay line and a writable coefficient bank, and computes each output with one shared multiply-accumulate unit over TAPS cycles. It keeps the run/busy handshake of the fixed 32-tap bank, and adds runtime coefficient loading, an output-valid strobe, delay-line clear, configurable output scaling and optional saturation.

## Interface
- DATA_W, 16: sample and output width, signed two's complement.
- COEFF_W, 16: coefficient width, signed (Q1.(COEFF_W-1) by convention).
- TAPS, 32: filter length, ≥2.
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before output.
- Derived localparams: ADDR_W = $clog2(TAPS); ACC_W = DATA_W+COEFF_W+$clog2(TAPS).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  request: filter one new sample.
- sample_in  in  DATA_W  sample, captured on the accepting edge.
- busy  out  1  combinational: run | (state != IDLE).
- out_valid  out  1  one-cycle pulse when filter_data updates.
- filter_data  out  DATA_W  last result, held between updates.
- coeff_we  in  1  coefficient write strobe.
- coeff_addr  in  ADDR_W  coefficient index k.
- coeff_wdata  in  COEFF_W  coefficient value.
- clear  in  1  zero the delay line.

## Operation
- Output y = Σ_{k=0}^{TAPS-1} c[k]·x[k]. x[0] is the newest sample and x[TAPS-1] the oldest.
- Reset values: state IDLE, delay line 0, all coefficients 0, accumulator 0, tap index 0, filter_data 0, out_valid 0.
- IDLE: on run=1 (and clear=0), shift x[k]←x[k-1] and x[0]←sample_in, clear the accumulator, set index 0, then go to MAC.
- MAC: each cycle, acc += x[idx]·c[idx] and idx++. After the idx=TAPS-1 accumulate, go to OUT.
- OUT: register the scaled result into filter_data, assert out_valid for exactly one cycle, then go to IDLE.
- Arithmetic:
  - Products are full precision, DATA_W+COEFF_W signed.
  - ACC_W is wide enough that the accumulator cannot overflow.
  - Result is acc >>> OUT_SHIFT (arithmetic shift, floor rounding), then narrowed to DATA_W as set by the Configuration section.
- Coefficient writes:
  - Accepted only in IDLE. Ignored while MAC/OUT.
  - Ignored when coeff_addr ≥ TAPS.
  - A write on the same edge as an accepted run takes effect for that computation.
- clear:
  - Acts only in IDLE. Zeroes all x[k]; coefficients are untouched.
  - If clear and run are both high, clear wins and run is not accepted.
  - Ignored while busy.
- run while state ≠ IDLE is ignored; there is no queueing.
- rst_n low at any time, including mid-MAC, returns everything to the reset values immediately. The in-flight result is discarded and no out_valid is produced.

## Timing
- Accepting edge E0 → MAC accumulates on edges E1..E_TAPS → filter_data and out_valid update on E_{TAPS+1}.
- out_valid is high for the cycle after E_{TAPS+1}, and state is IDLE in that same cycle.
- The next run is accepted earliest at E_{TAPS+2}. Throughput is 1 sample per TAPS+2 cycles.
- With run held high continuously, samples are accepted every TAPS+2 cycles.
- busy goes high combinationally with run, and falls in the cycle after E_{TAPS+1} if run=0.
- filter_data is stable except on out_valid edges.

## Configuration
- FIR_SATURATE_EN defined: the shifted result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FIR_SATURATE_EN undefined: the low DATA_W bits of the shifted result are taken, so the value wraps.

## Structure
- Package fir_pkg holds:
  - the state enum fir_state_t: IDLE, MAC, OUT;
  - a function for ACC_W;
  - the saturate/narrow function.
- Sub-module fir_mac_unit is the signed multiply-accumulate with clear, enable, ACC_W accumulator and a registered output. It is instantiated once.
- The delay line and coefficient bank stay in the top module as register arrays.

## Test plan
- Single tap:
  - Stimulus: reset; c[0]=0x7FFF, others 0; run with sample_in=0x1234.
  - Response: out_valid exactly at E_{TAPS+1}; filter_data=0x1233.
- Impulse response:
  - Stimulus: c[k]=k·0x0100; run with 0x4000, then 31 runs with 0.
  - Response: output n = n·0x0080 for n=0..31.
- Saturation:
  - Stimulus: all c=0x7FFF; 32 runs of 0x7FFF.
  - Response: last output 0x7FFF with FIR_SATURATE_EN, 0xFFC0 without.
  - Stimulus: all c=0x7FFF; samples of -0x8000.
  - Response: 0x8000 with FIR_SATURATE_EN.
- Handshake:
  - Stimulus: run held high.
  - Response: accepts every 34 cycles (TAPS=32).
  - Stimulus: run pulse or coeff_we while in MAC.
  - Response: ignored; coefficient unchanged.
  - Stimulus: coeff_addr ≥ TAPS.
  - Response: ignored.
- Reset mid-MAC:
  - Stimulus: rst_n low at E10.
  - Response: busy=0, out_valid never pulses, filter_data=0; the next run (coefficients now 0) gives 0.
- Clear:
  - Stimulus: load data; assert clear with run in IDLE, then run with 0.
  - Response: first run rejected; result 0 with coefficients retained.
